// File: rtl/wb_regfile_if.sv
// Writeback/Decode bus of the register file.
// The master side drives the MEM/WB fields and the Decode read addresses; the register file is the slave.
interface wb_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             RF_WENW;
    logic [1:0]       sel_ldW;
    logic [XLEN-1:0]  resultW;
    logic [XLEN-1:0]  dm_rdW;
    logic [4:0]       rdW;
    logic [XLEN-1:0]  PCp4W;
    logic             validW;
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [XLEN-1:0]  rd1D;
    logic [XLEN-1:0]  rd2D;
    logic [XLEN-1:0]  wb_dataW;
    logic [CNT_W-1:0] instret;

    modport master (
        output RF_WENW, sel_ldW, resultW, dm_rdW, rdW, PCp4W, validW, rs1D, rs2D,
        input  rd1D, rd2D, wb_dataW, instret
    );

    modport slave (
        input  RF_WENW, sel_ldW, resultW, dm_rdW, rdW, PCp4W, validW, rs1D, rs2D,
        output rd1D, rd2D, wb_dataW, instret
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage of the RV32I core: writeback mux, 32x32 register file with
// write-to-read bypass for Decode, and the retired-instruction counter.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave wb
);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic [XLEN-1:0]  wbData;
    logic             retiring;
    logic             writeEn;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;

    always_comb begin
        unique case (wb.sel_ldW)
            2'b01:   wbData = wb.dm_rdW;
            2'b10:   wbData = wb.PCp4W;
            default: wbData = wb.resultW;
        endcase
    end

    assign retiring = wb.RF_WENW && wb.validW;
    assign writeEn  = retiring && (wb.rdW != 5'd0);

    // x0 masking takes priority over the bypass so x0 stays zero even while it is the write target
    always_comb begin
        rd1 = regs_q[wb.rs1D];
        if (wb.rs1D == 5'd0) begin
            rd1 = '0;
        end else if (retiring && (wb.rdW == wb.rs1D)) begin
            rd1 = wbData;
        end
    end

    always_comb begin
        rd2 = regs_q[wb.rs2D];
        if (wb.rs2D == 5'd0) begin
            rd2 = '0;
        end else if (retiring && (wb.rdW == wb.rs2D)) begin
            rd2 = wbData;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (writeEn) begin
            regs_d[wb.rdW] = wbData;
        end
    end

    assign instret_d = wb.validW ? instret_q + CNT_W'(1) : instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            instret_q <= '0;
        end else begin
            regs_q    <= regs_d;
            instret_q <= instret_d;
        end
    end

    assign wb.wb_dataW = wbData;
    assign wb.rd1D     = rd1;
    assign wb.rd2D     = rd2;
    assign wb.instret  = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against an array-based architectural model of the register file.
module tb_wb_regfile;

    logic clk;
    logic rst;

    wb_regfile_if #(.XLEN(32), .CNT_W(64)) bus ();
    wb_regfile_if #(.XLEN(32), .CNT_W(4))  smallBus ();

    wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    // Narrow counter instance so counter wrap-around can be reached in a few cycles
    wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(4)) dutSmall (
        .clk (clk),
        .rst (rst),
        .wb  (smallBus)
    );

    int checks = 0;
    int fails  = 0;

    logic [31:0] model [32];
    logic [63:0] modelCount;
    int          smallCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expWb();
        case (bus.sel_ldW)
            2'd1:    return bus.dm_rdW;
            2'd2:    return bus.PCp4W;
            default: return bus.resultW;
        endcase
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (bus.RF_WENW && bus.validW && bus.rdW == addr) return expWb();
        return model[addr];
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wen, input logic valid, input logic [1:0] sel,
                                 input logic [31:0] res, input logic [31:0] dm, input logic [31:0] pc,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.RF_WENW = wen;
        bus.validW  = valid;
        bus.sel_ldW = sel;
        bus.resultW = res;
        bus.dm_rdW  = dm;
        bus.PCp4W   = pc;
        bus.rdW     = rd;
        bus.rs1D    = rs1;
        bus.rs2D    = rs2;
        #2;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".wb_dataW"}, {32'd0, bus.wb_dataW}, {32'd0, expWb()});
        checkVal({tag, ".rd1D"},     {32'd0, bus.rd1D},     {32'd0, expRead(bus.rs1D)});
        checkVal({tag, ".rd2D"},     {32'd0, bus.rd2D},     {32'd0, expRead(bus.rs2D)});
        checkVal({tag, ".instret"},  bus.instret,           modelCount);
    endtask

    // Advance one clock and apply the architectural effect of the current inputs to the model
    task automatic stepClock();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            modelCount = 64'd0;
            smallCount = 0;
        end else begin
            if (bus.RF_WENW && bus.validW && bus.rdW != 5'd0) model[bus.rdW] = expWb();
            if (bus.validW) modelCount = modelCount + 64'd1;
            if (smallBus.validW) smallCount = (smallCount + 1) % 16;
        end
        #1;
    endtask

    initial begin
        logic [63:0] base;
        logic [4:0]  rd;

        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        modelCount = 64'd0;
        smallCount = 0;
        smallBus.RF_WENW = 1'b0;
        smallBus.validW  = 1'b0;
        smallBus.sel_ldW = 2'd0;
        smallBus.resultW = 32'd0;
        smallBus.dm_rdW  = 32'd0;
        smallBus.PCp4W   = 32'd0;
        smallBus.rdW     = 5'd0;
        smallBus.rs1D    = 5'd0;
        smallBus.rs2D    = 5'd0;

        $display("[TB] reset and read-back of all registers");
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        stepClock();
        stepClock();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'(a), 5'(31 - a));
            checkVal("reset.rd1D", {32'd0, bus.rd1D}, 64'd0);
            checkVal("reset.rd2D", {32'd0, bus.rd2D}, 64'd0);
        end
        checkVal("reset.instret", bus.instret, 64'd0);
        checkVal("reset.smallInstret", {60'd0, smallBus.instret}, 64'd0);

        $display("[TB] ALU writeback with same-cycle bypass");
        applyStimulus(1'b1, 1'b1, 2'd0, 32'hDEADBEEF, 32'h1111_1111, 32'h2222_2222, 5'd5, 5'd5, 5'd5);
        checkVal("bypass.rd1D", {32'd0, bus.rd1D}, 64'hDEADBEEF);
        checkVal("bypass.rd2D", {32'd0, bus.rd2D}, 64'hDEADBEEF);
        checkOutput("bypass");
        stepClock();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
        checkVal("stored.x5", {32'd0, bus.rd1D}, 64'hDEADBEEF);
        checkVal("stored.instret", bus.instret, 64'd1);

        $display("[TB] load and link writeback");
        applyStimulus(1'b1, 1'b1, 2'd1, 32'hAAAA_AAAA, 32'h0000_00FF, 32'hBBBB_BBBB, 5'd7, 5'd0, 5'd0);
        checkVal("load.wb_dataW", {32'd0, bus.wb_dataW}, 64'hFF);
        stepClock();
        applyStimulus(1'b1, 1'b1, 2'd2, 32'hAAAA_AAAA, 32'hCCCC_CCCC, 32'h0000_0104, 5'd1, 5'd7, 5'd1);
        checkVal("link.wb_dataW", {32'd0, bus.wb_dataW}, 64'h104);
        checkVal("link.rd2D", {32'd0, bus.rd2D}, 64'h104);
        checkVal("load.x7", {32'd0, bus.rd1D}, 64'hFF);
        stepClock();
        applyStimulus(1'b1, 1'b1, 2'd3, 32'h5A5A_0003, 32'hCCCC_CCCC, 32'hDDDD_DDDD, 5'd9, 5'd1, 5'd9);
        checkVal("link.x1", {32'd0, bus.rd1D}, 64'h104);
        checkVal("reserved.wb_dataW", {32'd0, bus.wb_dataW}, 64'h5A5A_0003);
        stepClock();

        $display("[TB] writes to x0 are discarded");
        base = modelCount;
        applyStimulus(1'b1, 1'b1, 2'd0, 32'd1234, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        checkVal("x0same.rd1D", {32'd0, bus.rd1D}, 64'd0);
        checkVal("x0same.rd2D", {32'd0, bus.rd2D}, 64'd0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        checkVal("x0next.rd1D", {32'd0, bus.rd1D}, 64'd0);
        checkVal("x0next.rd2D", {32'd0, bus.rd2D}, 64'd0);
        checkVal("x0.instret", bus.instret, base + 64'd1);

        $display("[TB] retire counting with and without writes");
        base = modelCount;
        for (int i = 0; i < 10; i++) begin
            rd = 5'($urandom_range(1, 31));
            applyStimulus(!(i inside {1, 3, 6, 8}), 1'b1, 2'($urandom_range(0, 3)), $urandom,
                          $urandom, $urandom, rd, rd, 5'($urandom_range(0, 31)));
            checkOutput("count");
            stepClock();
        end
        for (int i = 0; i < 3; i++) begin
            rd = 5'($urandom_range(1, 31));
            applyStimulus(1'b1, 1'b0, 2'd0, $urandom, 32'd0, 32'd0, rd, rd, 5'd0);
            checkVal("bubble.rd1D", {32'd0, bus.rd1D}, {32'd0, model[rd]});
            stepClock();
        end
        checkVal("count.instret", bus.instret, base + 64'd10);

        $display("[TB] counter wrap on the narrow instance");
        smallBus.validW = 1'b1;
        for (int i = 0; i < 15; i++) stepClock();
        checkVal("wrap.before", {60'd0, smallBus.instret}, 64'd15);
        stepClock();
        smallBus.validW = 1'b0;
        #1;
        checkVal("wrap.after", {60'd0, smallBus.instret}, 64'd0);
        checkVal("wrap.model", {60'd0, smallBus.instret}, 64'(smallCount));

        $display("[TB] reset coinciding with a write");
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h0000_0033, 32'd0, 32'd0, 5'd3, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0);
        checkVal("prereset.x3", {32'd0, bus.rd1D}, 64'h33);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h0000_0777, 32'd0, 32'd0, 5'd3, 5'd0, 5'd0);
        stepClock();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd5);
        checkVal("rstwrite.x3", {32'd0, bus.rd1D}, 64'd0);
        checkVal("rstwrite.x5", {32'd0, bus.rd2D}, 64'd0);
        checkVal("rstwrite.instret", bus.instret, 64'd0);

        $display("[TB] randomized traffic against the model");
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            rd  = 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          $urandom, $urandom, $urandom, rd,
                          ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
            checkOutput("random");
            stepClock();
        end
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'(a), 5'(a));
            checkOutput("final");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
